// File: rtl/lcd_frame_monitor.sv
// -----------------------------------------------------------------------------
// lcd_frame_monitor
//
// Passive checker for an LCD pixel stream. NCLK is a slow pixel clock seen as
// a plain signal in the CLK domain; each rising edge of NCLK is one pixel
// strobe. On every strobe the monitor samples HD/VD/DEN/RGB, measures line
// length, DEN count per line, lines per frame and active lines per frame,
// and sums the DEN-qualified pixels. Each VD falling edge after the first
// closes a frame and latches a report.
//
// Ports
//   CLK         in   system clock (only clock)
//   RST         in   synchronous active-high reset
//   NCLK        in   pixel clock as a CLK-domain signal
//   HD, VD      in   horizontal / vertical sync, active low
//   DEN         in   data enable, active high
//   R, G, B     in   8-bit colour components
//   FRAME_DONE  out  one-CLK pulse when a frame report is latched
//   FRAME_OK    out  last reported frame had no error flags
//   ERR         out  [0] line length, [1] DEN count, [2] line count,
//                    [3] active-line count of the last frame
//   ACT_LINES   out  active-line count of the last frame
//   FRAME_CHK   out  32-bit pixel sum of the last frame
//   FRAME_CNT   out  frames reported since reset (wraps)
// -----------------------------------------------------------------------------
module lcd_frame_monitor #(
    parameter int H_TOTAL  = 1056,
    parameter int H_ACTIVE = 800,
    parameter int V_TOTAL  = 525,
    parameter int V_ACTIVE = 480
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        NCLK,
    input  logic        HD,
    input  logic        VD,
    input  logic        DEN,
    input  logic [7:0]  R,
    input  logic [7:0]  G,
    input  logic [7:0]  B,
    output logic        FRAME_DONE,
    output logic        FRAME_OK,
    output logic [3:0]  ERR,
    output logic [10:0] ACT_LINES,
    output logic [31:0] FRAME_CHK,
    output logic [15:0] FRAME_CNT
);

    localparam logic [10:0] H_TOTAL_W  = 11'(H_TOTAL);
    localparam logic [10:0] H_ACTIVE_W = 11'(H_ACTIVE);
    localparam logic [10:0] V_TOTAL_W  = 11'(V_TOTAL);
    localparam logic [10:0] V_ACTIVE_W = 11'(V_ACTIVE);

    typedef enum logic {SEARCH, FRAME} state_t;

    state_t      state, state_n;

    logic        nclk_q, hd_q, vd_q;
    logic        pix_en, hd_fall, vd_fall;

    logic [10:0] pix_cnt,  pix_cnt_n;
    logic [10:0] den_cnt,  den_cnt_n;
    logic [10:0] line_cnt, line_cnt_n;
    logic [10:0] act_cnt,  act_cnt_n;
    logic [31:0] acc,      acc_n;
    logic        e0, e0_n, e1, e1_n;
    logic        line_valid, line_valid_n;

    logic        done_n, ok_n;
    logic [3:0]  err_n;
    logic [10:0] act_lines_n;
    logic [31:0] chk_n;
    logic [15:0] cnt_n;

    // Counters stick at all-ones so a runaway line or frame cannot alias
    // back to a plausible value.
    function automatic logic [10:0] sat_inc(input logic [10:0] v);
        return (v == 11'h7FF) ? v : v + 11'd1;
    endfunction

    // Strobe and edge detection. hd_q/vd_q only advance on strobes, so an
    // edge is a change between two consecutive pixel samples.
    assign pix_en  = NCLK & ~nclk_q;
    assign hd_fall = pix_en & hd_q & ~HD;
    assign vd_fall = pix_en & vd_q & ~VD;

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves one
        // unassigned, which would infer a latch.
        state_n      = state;
        pix_cnt_n    = pix_cnt;
        den_cnt_n    = den_cnt;
        line_cnt_n   = line_cnt;
        act_cnt_n    = act_cnt;
        acc_n        = acc;
        e0_n         = e0;
        e1_n         = e1;
        line_valid_n = line_valid;
        done_n       = 1'b0;
        ok_n         = FRAME_OK;
        err_n        = ERR;
        act_lines_n  = ACT_LINES;
        chk_n        = FRAME_CHK;
        cnt_n        = FRAME_CNT;

        case (state)
            SEARCH: begin
                if (vd_fall) begin
                    state_n      = FRAME;
                    pix_cnt_n    = '0;
                    den_cnt_n    = '0;
                    line_cnt_n   = '0;
                    act_cnt_n    = '0;
                    acc_n        = '0;
                    e0_n         = 1'b0;
                    e1_n         = 1'b0;
                    line_valid_n = 1'b0;
                end
            end

            FRAME: begin
                if (pix_en) begin
                    // Line bookkeeping comes first so that an HD fall on the
                    // closing VD strobe is charged to the closing frame.
                    if (hd_fall) begin
                        if (line_valid) begin
                            if (pix_cnt != H_TOTAL_W)
                                e0_n = 1'b1;
                            if (den_cnt != '0 && den_cnt != H_ACTIVE_W)
                                e1_n = 1'b1;
                            if (den_cnt != '0)
                                act_cnt_n = sat_inc(act_cnt);
                        end
                        line_cnt_n   = sat_inc(line_cnt);
                        line_valid_n = 1'b1;
                        pix_cnt_n    = 11'd1;
                        den_cnt_n    = {10'd0, DEN};
                    end else begin
                        pix_cnt_n = sat_inc(pix_cnt);
                        if (DEN)
                            den_cnt_n = sat_inc(den_cnt);
                    end

                    if (DEN)
                        acc_n = acc + {8'h00, R, G, B};

                    if (vd_fall) begin
                        err_n       = {act_cnt_n != V_ACTIVE_W,
                                       line_cnt_n != V_TOTAL_W,
                                       e1_n, e0_n};
                        ok_n        = (err_n == 4'd0);
                        act_lines_n = act_cnt_n;
                        chk_n       = acc_n;
                        cnt_n       = FRAME_CNT + 16'd1;
                        done_n      = 1'b1;

                        pix_cnt_n    = '0;
                        den_cnt_n    = '0;
                        line_cnt_n   = '0;
                        act_cnt_n    = '0;
                        acc_n        = '0;
                        e0_n         = 1'b0;
                        e1_n         = 1'b0;
                        line_valid_n = 1'b0;
                    end
                end
            end

            default: state_n = SEARCH;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= SEARCH;
            nclk_q     <= 1'b1;
            hd_q       <= 1'b1;
            vd_q       <= 1'b1;
            pix_cnt    <= '0;
            den_cnt    <= '0;
            line_cnt   <= '0;
            act_cnt    <= '0;
            acc        <= '0;
            e0         <= 1'b0;
            e1         <= 1'b0;
            line_valid <= 1'b0;
            FRAME_DONE <= 1'b0;
            FRAME_OK   <= 1'b0;
            ERR        <= '0;
            ACT_LINES  <= '0;
            FRAME_CHK  <= '0;
            FRAME_CNT  <= '0;
        end else begin
            state      <= state_n;
            nclk_q     <= NCLK;
            if (pix_en) begin
                hd_q <= HD;
                vd_q <= VD;
            end
            pix_cnt    <= pix_cnt_n;
            den_cnt    <= den_cnt_n;
            line_cnt   <= line_cnt_n;
            act_cnt    <= act_cnt_n;
            acc        <= acc_n;
            e0         <= e0_n;
            e1         <= e1_n;
            line_valid <= line_valid_n;
            FRAME_DONE <= done_n;
            FRAME_OK   <= ok_n;
            ERR        <= err_n;
            ACT_LINES  <= act_lines_n;
            FRAME_CHK  <= chk_n;
            FRAME_CNT  <= cnt_n;
        end
    end

endmodule

// File: doc/lcd_frame_monitor.md
Name: lcd_frame_monitor

Overview:
Passive downstream checker for the LCD text/timing stage output (NCLK, HD, VD, DEN, R, G, B).
It runs in the CLK domain, samples the stream on each rising edge of NCLK, and measures line/frame timing against parameters.
Per frame it reports a pixel checksum and error flags, for use in benches and as an on-chip self-test monitor.

Parameters:
H_TOTAL, 1056, pixel strobes per line (HD falling edge to HD falling edge)
H_ACTIVE, 800, DEN-high strobes required in each active line
V_TOTAL, 525, lines per frame (HD falling edges per VD period)
V_ACTIVE, 480, lines per frame containing at least one DEN-high strobe

Ports:
CLK  in  1  system clock, only clock in the block
RST  in  1  synchronous, active-high reset
NCLK  in  1  LCD pixel clock as a CLK-domain signal; its rising edge marks a pixel
HD  in  1  horizontal sync, active low
VD  in  1  vertical sync, active low
DEN  in  1  data enable, active high
R  in  8  red
G  in  8  green
B  in  8  blue
FRAME_DONE  out  1  one-CLK pulse when a frame report is latched
FRAME_OK  out  1  1 when the last reported frame had ERR == 0
ERR  out  4  last frame flags: [0] line length != H_TOTAL, [1] DEN count != H_ACTIVE, [2] line count != V_TOTAL, [3] active lines != V_ACTIVE
ACT_LINES  out  11  active-line count of the last frame
FRAME_CHK  out  32  checksum of the last frame
FRAME_CNT  out  16  frames reported since reset, wraps at 65535 -> 0

Behaviour:
- Strobe
  - pix_en = NCLK & ~nclk_q, where nclk_q is NCLK registered.
  - nclk_q resets to 1, so there is no false strobe right after reset.
  - HD, VD, DEN, R, G, B are sampled only when pix_en = 1.
  - hd_q and vd_q hold the previous sampled values and reset to 1.
- Edges: a falling edge is detected at a strobe where the sample is 0 and the stored value is 1.
- Reset (RST = 1 on a CLK edge)
  - State returns to SEARCH.
  - All counters, accumulators and outputs go to 0.
  - A reset in mid-frame discards the partial frame and produces no report.
- FSM states: SEARCH, FRAME.
  - SEARCH -> FRAME on a VD falling edge. All working counters clear; no report is made.
  - FRAME -> FRAME on a VD falling edge: the frame is closed and reported, then counters clear.
- Line accounting, in FRAME only:
  - pix_cnt counts strobes since the last HD falling edge (11 bits, saturates at 2047).
  - den_cnt counts DEN-high strobes in the line (11 bits, saturates at 2047).
  - line_valid is 0 until the first HD falling edge in FRAME.
  - On an HD falling edge with line_valid = 1:
    - If pix_cnt != H_TOTAL, set e0.
    - If den_cnt != 0 and den_cnt != H_ACTIVE, set e1.
    - If den_cnt != 0, increment act_cnt.
  - Every HD falling edge in FRAME increments line_cnt. pix_cnt restarts at 1 and den_cnt restarts at DEN.
- Checksum: on every strobe in FRAME with DEN = 1, acc <= acc + {8'h00,R,G,B}, modulo 2^32.
- Frame close: on a VD falling edge in FRAME.
  - If HD falls on the same strobe, the line and line_cnt update is applied first and belongs to the closing frame.
  - The pixel in that strobe is included in acc.
  - e2 = (line_cnt != V_TOTAL); e3 = (act_cnt != V_ACTIVE).
  - On the same CLK edge:
    - ERR, ACT_LINES, FRAME_CHK and FRAME_OK latch.
    - FRAME_CNT increments.
    - FRAME_DONE = 1 for exactly one CLK.
  - Working counters and e0..e3 clear; line_valid clears.
- Outputs hold their values between reports.
- DEN outside HD/VD blanking is not an error by itself; it is caught only through the counts.
- There is no back-pressure. The block never drives the LCD stream.

Test Plan:
- Nominal: bench generates 2 frames, NCLK = CLK/2, 800x480 active in a 1056x525 period, every pixel 24'h000001 -> FRAME_DONE after the 2nd VD fall only; FRAME_OK=1, ERR=0, ACT_LINES=480, FRAME_CHK=384000, FRAME_CNT=1.
- Short line: line 100 is 1055 strobes long -> ERR=4'b0001, FRAME_OK=0. The next clean frame gives ERR=0.
- Short DEN: line 50 has DEN high for 799 strobes -> ERR[1]=1 and FRAME_CHK=383999 with all-ones pixel value 1.
- Frame shape: 524 lines with 479 active -> ERR=4'b1100, ACT_LINES=479.
- Reset mid-frame: RST pulsed at line 200 -> all outputs 0. The next VD fall produces no FRAME_DONE; the following one reports a clean frame with FRAME_CNT=1.
- Coincident edges: HD and VD fall on the same strobe with total 525 lines -> ERR[2]=0. The line is counted in the closing frame.
